pc_gen: RTL

Parametrised program-counter generator for the fetch front end. It replaces the fixed PC register with the following:
- a valid/ready handshake toward instruction fetch;
- prioritised redirect sources (trap over jump);
- target alignment checking;
- an explicit boot/run/stall state machine;
- an accepted-fetch counter.

It sits between the execute/CSR redirect logic and the instruction-memory request port.

---
 rtl/pc_gen_pkg.sv | 17 +
 rtl/pc_gen.sv | 113 +++++++++++
 2 files changed

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared fetch-front-end constants and pc_gen state encoding
package pc_gen_pkg;

    localparam int          PC_XLEN      = 32;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    typedef enum logic [1:0] {
        BOOT  = ST_BOOT,
        RUN   = ST_RUN,
        STALL = ST_STALL
    } pc_state_e;

endpackage

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator with redirects, alignment check and fetch handshake
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               XLEN       = PC_XLEN,
    parameter logic [XLEN-1:0]  RESET_VEC  = XLEN'(PC_RESET_VEC),
    parameter int               INC        = 4,
    parameter int               ALIGN_BITS = 2,
    parameter int               CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trap_en_i,
    input  logic [XLEN-1:0]  trap_addr_i,
    input  logic             jump_en_i,
    input  logic [XLEN-1:0]  jump_addr_i,
    input  logic             hold_flag_i,
    input  logic             pc_ready_i,
    output logic [XLEN-1:0]  pc_o,
    output logic             pc_valid_o,
    output logic             redirect_o,
    output logic             misalign_o,
    output logic [XLEN-1:0]  misalign_addr_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    // Ones in every bit a legal target may have set.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));

    pc_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             redirect_q, redirect_d;
    logic             misalign_q, misalign_d;
    logic [XLEN-1:0]  misalign_addr_q, misalign_addr_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

    logic transfer;
    logic jump_misaligned;

    assign transfer        = pc_valid_q & pc_ready_i;
    assign jump_misaligned = (jump_addr_i & ~ALIGN_MASK) != '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = hold_flag_i ? STALL : RUN;
            RUN:     if (hold_flag_i)  state_d = STALL;
            STALL:   if (!hold_flag_i) state_d = RUN;
            default: state_d = BOOT;
        endcase
        pc_valid_d = (state_d == RUN);
    end

    // Next-pc priority: trap > aligned jump > accepted increment > hold.
    always_comb begin
        pc_d            = pc_q;
        redirect_d      = 1'b0;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        if (trap_en_i) begin
            pc_d       = trap_addr_i & ALIGN_MASK;
            redirect_d = 1'b1;
        end else if (jump_en_i && !jump_misaligned) begin
            pc_d       = jump_addr_i;
            redirect_d = 1'b1;
        end else begin
            if (transfer) begin
                pc_d = pc_q + XLEN'(INC);
            end
            if (jump_en_i) begin
                misalign_d      = 1'b1;
                misalign_addr_d = jump_addr_i;
            end
        end
    end

    // The old pc is still counted when a redirect lands on the same edge.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (transfer) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= BOOT;
            pc_q            <= RESET_VEC;
            pc_valid_q      <= 1'b0;
            redirect_q      <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            fetch_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pc_valid_q      <= pc_valid_d;
            redirect_q      <= redirect_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
            fetch_cnt_q     <= fetch_cnt_d;
        end
    end

    assign pc_o            = pc_q;
    assign pc_valid_o      = pc_valid_q;
    assign redirect_o      = redirect_q;
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;
    assign fetch_cnt_o     = fetch_cnt_q;

endmodule
